// File: rtl/lamp_sequencer_if.sv
// Switch inputs and lamp/buzzer/status-digit outputs of the lamp sequencer.
interface lamp_sequencer_if;
   logic       S1;
   logic       S2;
   logic       S3;
   logic       F;
   logic       Buzzer;
   logic [6:0] LED;

   modport master (output S1, S2, S3, input F, Buzzer, LED);
   modport slave  (input S1, S2, S3, output F, Buzzer, LED);
endinterface

// File: rtl/lamp_sequencer.sv
// Three-way lamp controller: synchronised, debounced switches feed a parity
// toggle detector that drives an IDLE/ON/WARN sequencer from one shared timer.
module lamp_debounce #(
   parameter int C_NUM    = 28,
   parameter int DB_TICKS = 500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_i,
   output logic db_o,
   output logic settled_o
);
   localparam logic [C_NUM-1:0] DB_LAST = C_NUM'(DB_TICKS - 1);

   logic             sync1_q, sync2_q, db_q;
   logic [C_NUM-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sw_i;
         sync2_q <= sync1_q;
         if (sync2_q != db_q) begin
            if (cnt_q == DB_LAST) begin
               db_q  <= sync2_q;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign db_o      = db_q;
   assign settled_o = (cnt_q == '0) && (sync2_q == db_q);
endmodule

module lamp_sequencer #(
   parameter int C_NUM       = 28,
   parameter int DB_TICKS    = 500_000,
   parameter int ON_TICKS    = 250_000_000,
   parameter int WARN_TICKS  = 100_000_000,
   parameter int BLINK_TICKS = 12_500_000,
   parameter int BUZ_TICKS   = 25_000_000
) (
   input  logic              clk,
   input  logic              rst,
   lamp_sequencer_if.slave   io
);
   localparam int NUM_SW = 3;

   localparam logic [C_NUM-1:0] ON_RLD    = C_NUM'(ON_TICKS - 1);
   localparam logic [C_NUM-1:0] WARN_RLD  = C_NUM'(WARN_TICKS - 1);
   localparam logic [C_NUM-1:0] BLINK_RLD = C_NUM'(BLINK_TICKS - 1);
   // Buzzer sounds while elapsed = WARN_TICKS - t_q < BUZ_TICKS, i.e. t_q above this.
   localparam logic [C_NUM-1:0] BUZ_THR   = C_NUM'(WARN_TICKS - BUZ_TICKS);

   localparam logic [6:0] LED_0 = 7'b1000000;
   localparam logic [6:0] LED_1 = 7'b1111001;
   localparam logic [6:0] LED_2 = 7'b0100100;

   typedef enum logic [1:0] {S_IDLE, S_ON, S_WARN} state_t;

   logic [NUM_SW-1:0] sw, db, settled;
   logic              parity, evt;
   logic              p_prev_q, armed_q;
   logic [1:0]        warm_q;

   state_t            state_q;
   logic [C_NUM-1:0]  t_q, blink_q;
   logic              f_q, buz_q;
   logic [6:0]        led_q;

   assign sw = {io.S3, io.S2, io.S1};

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      lamp_debounce #(.C_NUM(C_NUM), .DB_TICKS(DB_TICKS)) u_db (
         .clk       (clk),
         .rst       (rst),
         .sw_i      (sw[i]),
         .db_o      (db[i]),
         .settled_o (settled[i])
      );
   end

   assign parity = ^db;
   assign evt    = armed_q && (parity != p_prev_q);

   // Arming waits for the synchronisers to fill so the switch levels present
   // at reset are absorbed as the initial state rather than seen as a toggle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         warm_q   <= 2'b00;
         armed_q  <= 1'b0;
         p_prev_q <= 1'b0;
      end else begin
         warm_q   <= {warm_q[0], 1'b1};
         armed_q  <= armed_q | (warm_q[1] & (&settled));
         p_prev_q <= parity;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         blink_q <= '0;
         f_q     <= 1'b1;
         buz_q   <= 1'b1;
         led_q   <= LED_0;
      end else if (evt) begin
         state_q <= S_ON;
         t_q     <= ON_RLD;
         f_q     <= 1'b0;
         buz_q   <= 1'b1;
         led_q   <= LED_1;
      end else begin
         case (state_q)
            S_ON: begin
               if (t_q == '0) begin
                  state_q <= S_WARN;
                  t_q     <= WARN_RLD;
                  blink_q <= BLINK_RLD;
                  f_q     <= 1'b0;
                  buz_q   <= (BUZ_TICKS == 0);
                  led_q   <= LED_2;
               end else begin
                  t_q <= t_q - 1'b1;
               end
            end
            S_WARN: begin
               if (t_q == '0) begin
                  state_q <= S_IDLE;
                  f_q     <= 1'b1;
                  buz_q   <= 1'b1;
                  led_q   <= LED_0;
               end else begin
                  t_q   <= t_q - 1'b1;
                  buz_q <= !(t_q > BUZ_THR);
                  if (blink_q == '0) begin
                     blink_q <= BLINK_RLD;
                     f_q     <= ~f_q;
                  end else begin
                     blink_q <= blink_q - 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               f_q     <= 1'b1;
               buz_q   <= 1'b1;
               led_q   <= LED_0;
            end
         endcase
      end
   end

   assign io.F      = f_q;
   assign io.Buzzer = buz_q;
   assign io.LED    = led_q;
endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed bench for lamp_sequencer: vector table plus hand-written corner sequences.
module tb_lamp_sequencer;
   localparam logic [6:0] L0 = 7'b1000000;
   localparam logic [6:0] L1 = 7'b1111001;
   localparam logic [6:0] L2 = 7'b0100100;

   logic clk;
   logic rst;
   int   nvec;
   int   nerr;

   lamp_sequencer_if bus ();

   lamp_sequencer #(
      .C_NUM(8), .DB_TICKS(4), .ON_TICKS(20), .WARN_TICKS(8),
      .BLINK_TICKS(2), .BUZ_TICKS(3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] sw;   // {S3,S2,S1}
      int         n;    // cycles held; expectation checked after every one
      logic       f;
      logic       b;
      logic [6:0] led;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic f, input logic b, input logic [6:0] led);
      nvec++;
      if ({bus.F, bus.Buzzer, bus.LED} !== {f, b, led}) begin
         nerr++;
         $display("FAIL %s @%0t: got F=%b Buzzer=%b LED=%b, want F=%b Buzzer=%b LED=%b",
                  name, $time, bus.F, bus.Buzzer, bus.LED, f, b, led);
      end
   endtask

   // Inputs change at a negedge; outputs are checked at each following negedge.
   task automatic run(input string name, input logic [2:0] sw, input int n,
                      input logic f, input logic b, input logic [6:0] led);
      bus.S1 = sw[0];
      bus.S2 = sw[1];
      bus.S3 = sw[2];
      repeat (n) begin
         @(negedge clk);
         chk(name, f, b, led);
      end
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      rst  = 1'b1;
      bus.S1 = 1'b1;
      bus.S2 = 1'b0;
      bus.S3 = 1'b0;

      // Init: S1 already high through reset, then a single S2 toggle and a full cycle.
      tbl.push_back('{3'b001, 100, 1'b1, 1'b1, L0});
      tbl.push_back('{3'b011,   6, 1'b1, 1'b1, L0});
      tbl.push_back('{3'b011,   1, 1'b0, 1'b1, L1});
      tbl.push_back('{3'b011,  19, 1'b0, 1'b1, L1});
      tbl.push_back('{3'b011,   1, 1'b0, 1'b0, L2});
      tbl.push_back('{3'b011,   1, 1'b0, 1'b0, L2});
      tbl.push_back('{3'b011,   1, 1'b1, 1'b0, L2});
      tbl.push_back('{3'b011,   1, 1'b1, 1'b1, L2});
      tbl.push_back('{3'b011,   1, 1'b0, 1'b1, L2});
      tbl.push_back('{3'b011,   1, 1'b0, 1'b1, L2});
      tbl.push_back('{3'b011,   1, 1'b1, 1'b1, L2});
      tbl.push_back('{3'b011,   1, 1'b1, 1'b1, L2});
      tbl.push_back('{3'b011,  11, 1'b1, 1'b1, L0});
      // Bounce on S3: five 3-cycle pulses never complete the 4-cycle window.
      for (int p = 0; p < 5; p++) begin
         tbl.push_back('{3'b111, 3, 1'b1, 1'b1, L0});
         tbl.push_back('{3'b011, 3, 1'b1, 1'b1, L0});
      end
      tbl.push_back('{3'b011, 12, 1'b1, 1'b1, L0});

      repeat (3) @(negedge clk);
      chk("reset", 1'b1, 1'b1, L0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++)
         run($sformatf("vec%0d", i), tbl[i].sw, tbl[i].n, tbl[i].f, tbl[i].b, tbl[i].led);

      // Retrigger in ON: S1 toggled so its event lands when t=5; WARN moves out by 14.
      run("retrig_pre",  3'b010,  6, 1'b1, 1'b1, L0);
      run("retrig_evt",  3'b010,  1, 1'b0, 1'b1, L1);
      run("retrig_on",   3'b010,  7, 1'b0, 1'b1, L1);
      run("retrig_2nd",  3'b011,  7, 1'b0, 1'b1, L1);
      run("retrig_ext",  3'b011, 15, 1'b0, 1'b1, L1);
      // Mid-WARN toggle of S2 lands on elapsed=2 (buzzer still on).
      run("warn_pre",    3'b001,  4, 1'b0, 1'b1, L1);
      run("warn_entry",  3'b001,  1, 1'b0, 1'b0, L2);
      run("warn_e1",     3'b001,  1, 1'b0, 1'b0, L2);
      run("warn_cancel", 3'b001,  1, 1'b0, 1'b1, L1);
      run("warn_reon",   3'b001, 19, 1'b0, 1'b1, L1);
      run("warn2_entry", 3'b001,  1, 1'b0, 1'b0, L2);

      // Async reset between edges while the lamp and buzzer are active.
      #2 rst = 1'b1;
      #1 chk("async_rst", 1'b1, 1'b1, L0);
      @(negedge clk);
      rst = 1'b0;
      run("post_rst",    3'b001, 30, 1'b1, 1'b1, L0);

      // S1 and S2 flip together: parity unchanged. Then S3 alone toggles.
      run("simul",       3'b010, 20, 1'b1, 1'b1, L0);
      run("s3_pre",      3'b110,  6, 1'b1, 1'b1, L0);
      run("s3_evt",      3'b110,  1, 1'b0, 1'b1, L1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
